// File: rtl/maze_episode_ctrl.sv
// -----------------------------------------------------------------------------
// maze_episode_ctrl
//
// Purpose:
//   Moves one reinforcement-learning agent through a GRID_W x GRID_H maze, one
//   action at a time. Each action comes from the policy over a valid/ready
//   handshake. The controller works out the target cell, reads its type from
//   the maze map, and resolves the step: it moves the agent or bumps it back,
//   then assigns the reward. It reports each step and finishes the episode on
//   goal, trap or step limit.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start, abort      episode control (start only in IDLE, abort always)
//   action_valid/_ready, action   policy handshake (0 up,1 right,2 down,3 left)
//   map_rd_en/_addr, map_rd_data  maze map read port (data 1 cycle after en)
//   current_state     agent cell index (row*GRID_W + col)
//   step_valid, reward            per-step pulse and signed reward
//   episode_done, end_cause       end-of-episode pulse (0 goal,1 trap,2 timeout)
//   busy, step_count, episode_count   status
//
// Timing: an action accepted in cycle T gives step_valid in cycle T+3 for every
// outcome (WAIT_ACT -> CALC -> READ -> REPORT).
// -----------------------------------------------------------------------------
module maze_episode_ctrl #(
    parameter int GRID_W      = 5,
    parameter int GRID_H      = 5,
    parameter int START_STATE = 0,
    parameter int MAX_STEPS   = 64,
    parameter int R_STEP      = -1,
    parameter int R_WALL      = -5,
    parameter int R_GOAL      = 100,
    parameter int R_TRAP      = -100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        action_valid,
    output logic        action_ready,
    input  logic [1:0]  action,
    output logic        map_rd_en,
    output logic [4:0]  map_rd_addr,
    input  logic [3:0]  map_rd_data,
    output logic [6:0]  current_state,
    output logic        step_valid,
    output logic [7:0]  reward,
    output logic        episode_done,
    output logic [1:0]  end_cause,
    output logic        busy,
    output logic [7:0]  step_count,
    output logic [15:0] episode_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ACT = 3'd1,
        CALC     = 3'd2,
        READ     = 3'd3,
        REPORT   = 3'd4
    } state_t;

    localparam logic [6:0] GRID_W_L  = 7'(GRID_W);
    localparam logic [6:0] LAST_COL  = 7'(GRID_W - 1);
    localparam logic [6:0] LAST_ROW  = 7'(GRID_H - 1);
    localparam logic [6:0] START_CS  = 7'(START_STATE);
    localparam logic [6:0] START_ROW = 7'(START_STATE / GRID_W);
    localparam logic [6:0] START_COL = 7'(START_STATE % GRID_W);
    localparam logic [7:0] MAX_L     = 8'(MAX_STEPS);

    localparam logic [7:0] R_STEP_B = 8'(R_STEP);
    localparam logic [7:0] R_WALL_B = 8'(R_WALL);
    localparam logic [7:0] R_GOAL_B = 8'(R_GOAL);
    localparam logic [7:0] R_TRAP_B = 8'(R_TRAP);

    localparam logic [3:0] CELL_WALL = 4'd2;
    localparam logic [3:0] CELL_GOAL = 4'd3;
    localparam logic [3:0] CELL_TRAP = 4'd4;

    localparam logic [1:0] CAUSE_GOAL    = 2'd0;
    localparam logic [1:0] CAUSE_TRAP    = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    state_t     state_reg;
    logic [6:0] row_reg, col_reg;
    logic [6:0] cand_row_reg, cand_col_reg, cand_state_reg;
    logic       bump_reg;

    // Candidate cell, evaluated from the live action so the map read can be
    // issued during CALC and the fixed three-cycle latency holds.
    logic [6:0] cand_row, cand_col, cand_state;
    logic       cand_in_grid;

    always_comb begin
        cand_row     = row_reg;
        cand_col     = col_reg;
        cand_in_grid = 1'b0;
        case (action)
            2'd0: if (row_reg != 7'd0)   begin cand_row = row_reg - 7'd1; cand_in_grid = 1'b1; end
            2'd1: if (col_reg < LAST_COL) begin cand_col = col_reg + 7'd1; cand_in_grid = 1'b1; end
            2'd2: if (row_reg < LAST_ROW) begin cand_row = row_reg + 7'd1; cand_in_grid = 1'b1; end
            default: if (col_reg != 7'd0) begin cand_col = col_reg - 7'd1; cand_in_grid = 1'b1; end
        endcase
        cand_state = cand_row * GRID_W_L + cand_col;
    end

    // Step resolution from the map data returned in READ.
    logic       res_move, res_terminal;
    logic [7:0] res_reward;
    logic [1:0] res_cause;
    logic [7:0] step_inc;

    always_comb begin
        res_move     = 1'b1;
        res_terminal = 1'b0;
        res_reward   = R_STEP_B;
        res_cause    = CAUSE_TIMEOUT;
        if (bump_reg || map_rd_data == CELL_WALL) begin
            res_move   = 1'b0;
            res_reward = R_WALL_B;
        end else if (map_rd_data == CELL_GOAL) begin
            res_terminal = 1'b1;
            res_reward   = R_GOAL_B;
            res_cause    = CAUSE_GOAL;
        end else if (map_rd_data == CELL_TRAP) begin
            res_terminal = 1'b1;
            res_reward   = R_TRAP_B;
            res_cause    = CAUSE_TRAP;
        end
    end

    assign step_inc = step_count + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            row_reg        <= START_ROW;
            col_reg        <= START_COL;
            cand_row_reg   <= 7'd0;
            cand_col_reg   <= 7'd0;
            cand_state_reg <= 7'd0;
            bump_reg       <= 1'b0;
            current_state  <= START_CS;
            action_ready   <= 1'b0;
            map_rd_en      <= 1'b0;
            map_rd_addr    <= 5'd0;
            step_valid     <= 1'b0;
            reward         <= 8'd0;
            episode_done   <= 1'b0;
            end_cause      <= 2'd0;
            busy           <= 1'b0;
            step_count     <= 8'd0;
            episode_count  <= 16'd0;
        end else begin
            step_valid   <= 1'b0;
            episode_done <= 1'b0;
            if (abort) begin
                // Any in-flight step is dropped: no pulses, counters untouched.
                state_reg    <= IDLE;
                action_ready <= 1'b0;
                map_rd_en    <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            current_state <= START_CS;
                            row_reg       <= START_ROW;
                            col_reg       <= START_COL;
                            step_count    <= 8'd0;
                            busy          <= 1'b1;
                            action_ready  <= 1'b1;
                            state_reg     <= WAIT_ACT;
                        end
                    end
                    WAIT_ACT: begin
                        if (action_valid) begin
                            action_ready   <= 1'b0;
                            cand_row_reg   <= cand_row;
                            cand_col_reg   <= cand_col;
                            cand_state_reg <= cand_state;
                            bump_reg       <= !cand_in_grid;
                            map_rd_en      <= cand_in_grid;
                            map_rd_addr    <= cand_in_grid ? cand_state[4:0] : 5'd0;
                            state_reg      <= CALC;
                        end
                    end
                    CALC: begin
                        map_rd_en <= 1'b0;
                        state_reg <= READ;
                    end
                    READ: begin
                        if (res_move) begin
                            row_reg       <= cand_row_reg;
                            col_reg       <= cand_col_reg;
                            current_state <= cand_state_reg;
                        end
                        reward     <= res_reward;
                        step_valid <= 1'b1;
                        step_count <= step_inc;
                        // Terminal outcome outranks the step limit for end_cause.
                        if (res_terminal || step_inc == MAX_L) begin
                            episode_done  <= 1'b1;
                            end_cause     <= res_cause;
                            episode_count <= episode_count + 16'd1;
                        end
                        state_reg <= REPORT;
                    end
                    REPORT: begin
                        if (episode_done) begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            action_ready <= 1'b1;
                            state_reg    <= WAIT_ACT;
                        end
                    end
                    default: begin
                        state_reg    <= IDLE;
                        busy         <= 1'b0;
                        action_ready <= 1'b0;
                        map_rd_en    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maze_episode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_episode_ctrl
//
// Directed bench for maze_episode_ctrl with MAX_STEPS=4. A small map model
// returns cell types one cycle after each read strobe: cell 3 trap, cell 5
// goal, cell 6 wall, all other cells free.
// -----------------------------------------------------------------------------
module tb_maze_episode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        action_valid = 1'b0;
    logic        action_ready;
    logic [1:0]  action = 2'd0;
    logic        map_rd_en;
    logic [4:0]  map_rd_addr;
    logic [3:0]  map_rd_data;
    logic [6:0]  current_state;
    logic        step_valid;
    logic [7:0]  reward;
    logic        episode_done;
    logic [1:0]  end_cause;
    logic        busy;
    logic [7:0]  step_count;
    logic [15:0] episode_count;

    int checks = 0;
    int errors = 0;

    maze_episode_ctrl #(.MAX_STEPS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .action_valid  (action_valid),
        .action_ready  (action_ready),
        .action        (action),
        .map_rd_en     (map_rd_en),
        .map_rd_addr   (map_rd_addr),
        .map_rd_data   (map_rd_data),
        .current_state (current_state),
        .step_valid    (step_valid),
        .reward        (reward),
        .episode_done  (episode_done),
        .end_cause     (end_cause),
        .busy          (busy),
        .step_count    (step_count),
        .episode_count (episode_count)
    );

    always #5 clk = ~clk;

    // Map model: registered read, data valid the cycle after the strobe.
    logic [3:0] map_mem [25];
    initial begin
        for (int i = 0; i < 25; i++) map_mem[i] = 4'd0;
        map_mem[3] = 4'd4;
        map_mem[5] = 4'd3;
        map_mem[6] = 4'd2;
    end
    always_ff @(posedge clk)
        map_rd_data <= (map_rd_en && map_rd_addr < 5'd25) ? map_mem[map_rd_addr] : 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk) abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!action_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(action_ready), 32'd1);
    endtask

    // Offer one action and check the step reported at T+3.
    task automatic do_step(input logic [1:0] act, input logic exp_rden, input int exp_addr,
                           input int exp_rew, input int exp_state, input int exp_cnt,
                           input logic exp_done, input int exp_cause);
        wait_ready();
        action_valid = 1'b1;
        action = act;
        @(posedge clk); #1 action_valid = 1'b0;
        check("rd_en", 32'(map_rd_en), 32'(exp_rden));
        if (exp_rden) check("rd_addr", 32'(map_rd_addr), 32'(exp_addr));
        check("sv_t1", 32'(step_valid), 32'd0);
        @(posedge clk); #1;
        check("sv_t2", 32'(step_valid), 32'd0);
        @(posedge clk); #1;
        check("sv_t3", 32'(step_valid), 32'd1);
        check("reward", 32'(reward), 32'(exp_rew & 255));
        check("state", 32'(current_state), 32'(exp_state));
        check("step_count", 32'(step_count), 32'(exp_cnt));
        check("done", 32'(episode_done), 32'(exp_done));
        if (exp_done) check("end_cause", 32'(end_cause), 32'(exp_cause));
        $display("step act=%0d reward=%0d state=%0d count=%0d done=%0b cause=%0d",
                 act, $signed(reward), current_state, step_count, episode_done, end_cause);
    endtask

    initial begin
        int pulses;
        // Reset state
        #12;
        check("rst_state", 32'(current_state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(action_ready), 32'd0);
        check("rst_epcnt", 32'(episode_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: free moves right, right, down
        do_start();
        check("busy_start", 32'(busy), 32'd1);
        do_step(2'd1, 1'b1, 1, -1, 1, 1, 1'b0, 0);
        do_step(2'd1, 1'b1, 2, -1, 2, 2, 1'b0, 0);
        do_step(2'd2, 1'b1, 7, -1, 7, 3, 1'b0, 0);
        do_start();  // ignored outside IDLE
        check("start_ign_cnt", 32'(step_count), 32'd3);
        check("start_ign_st", 32'(current_state), 32'd7);
        do_abort();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cnt", 32'(step_count), 32'd3);
        check("abort_epcnt", 32'(episode_count), 32'd0);

        // 2: off-grid bumps at state 0
        do_start();
        check("restart_state", 32'(current_state), 32'd0);
        do_step(2'd0, 1'b0, 0, -5, 0, 1, 1'b0, 0);
        do_step(2'd3, 1'b0, 0, -5, 0, 2, 1'b0, 0);

        // 5a: abort during READ drops the step
        wait_ready();
        action_valid = 1'b1;
        action = 2'd1;
        @(posedge clk); #1 action_valid = 1'b0;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abrd_sv", 32'(step_valid), 32'd0);
        check("abrd_busy", 32'(busy), 32'd0);
        check("abrd_cnt", 32'(step_count), 32'd2);
        check("abrd_state", 32'(current_state), 32'd0);
        @(posedge clk); #1;
        check("abrd_sv2", 32'(step_valid), 32'd0);
        $display("abort in READ: busy=%0b step_count=%0d", busy, step_count);

        // 3: goal at cell 5
        do_start();
        do_step(2'd2, 1'b1, 5, 100, 5, 1, 1'b1, 0);
        check("goal_epcnt", 32'(episode_count), 32'd1);
        @(posedge clk); #1;
        check("goal_idle", 32'(busy), 32'd0);
        check("goal_done_pulse", 32'(episode_done), 32'd0);
        check("goal_hold", 32'(current_state), 32'd5);

        // 4: timeout after 4 steps
        do_start();
        do_step(2'd1, 1'b1, 1, -1, 1, 1, 1'b0, 0);
        do_step(2'd3, 1'b1, 0, -1, 0, 2, 1'b0, 0);
        do_step(2'd1, 1'b1, 1, -1, 1, 3, 1'b0, 0);
        do_step(2'd3, 1'b1, 0, -1, 0, 4, 1'b1, 2);
        check("to_epcnt", 32'(episode_count), 32'd2);
        @(posedge clk); #1;
        check("to_idle", 32'(busy), 32'd0);

        // 6: action_valid held high -> one step per handshake
        do_start();
        action_valid = 1'b1;
        action = 2'd1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (step_valid) pulses++;
        end
        action_valid = 1'b0;
        check("held_pulses", 32'(pulses), 32'd2);
        check("held_state", 32'(current_state), 32'd2);
        check("held_cnt", 32'(step_count), 32'd2);
        $display("held valid: pulses=%0d state=%0d", pulses, current_state);

        // 5b: reset during CALC
        wait_ready();
        action_valid = 1'b1;
        action = 2'd2;
        @(posedge clk); #1 action_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstc_state", 32'(current_state), 32'd0);
        check("rstc_outs", {busy, action_ready, map_rd_en, step_valid, episode_done, end_cause,
                            map_rd_addr, reward}, 32'd0);
        check("rstc_counts", {step_count, episode_count}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Wall bump then trap on the step that also hits the step limit
        do_start();
        do_step(2'd1, 1'b1, 1, -1, 1, 1, 1'b0, 0);
        do_step(2'd2, 1'b1, 6, -5, 1, 2, 1'b0, 0);
        do_step(2'd1, 1'b1, 2, -1, 2, 3, 1'b0, 0);
        do_step(2'd1, 1'b1, 3, -100, 3, 4, 1'b1, 1);
        check("trap_epcnt", 32'(episode_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
